// File: rtl/fill_sequencer.sv
// Run-time sequencer for the pill-bottling line: BCD pill/bottle counting,
// bottle-switch and hopper-starvation timing, and the operator-visible state code.
module fill_sequencer #(
    parameter int HOPPER_TIMEOUT = 3000,
    parameter int SWITCH_TIME    = 2000,
    parameter int MAX_ERRORS     = 3
) (
    input  logic        clk_1khz,
    input  logic        switch_clr,
    input  logic        start,
    input  logic        clr_err,
    input  logic        estop,
    input  logic        pill_pulse,
    input  logic        conveyor_ok,
    input  logic [11:0] target_pills,
    input  logic [7:0]  target_bottles,
    output logic [2:0]  state,
    output logic [11:0] now_pills,
    output logic [7:0]  now_bottles,
    output logic [1:0]  err_code,
    output logic [1:0]  alarm
);

    typedef enum logic [2:0] {
        ST_SETTING   = 3'd0,
        ST_RUNNING   = 3'd1,
        ST_SWITCHING = 3'd2,
        ST_DONE      = 3'd3,
        ST_ERROR     = 3'd4,
        ST_FATAL     = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_HOPPER   = 2'd1,
        ERR_CONVEYOR = 2'd2,
        ERR_ESTOP    = 2'd3
    } err_t;

    localparam logic [11:0] HOPPER_RELOAD = 12'(HOPPER_TIMEOUT);
    localparam logic [11:0] SWITCH_RELOAD = 12'(SWITCH_TIME);
    localparam logic [2:0]  ERROR_LIMIT   = 3'(MAX_ERRORS);

    // Ripple BCD increment: a 9 rolls to 0 and carries into the next digit.
    function automatic logic [11:0] bcd_inc3(input logic [11:0] v);
        logic [11:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (carry) begin
                if (v[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [7:0] bcd_inc2(input logic [7:0] v);
        logic [7:0] r;
        logic       carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < 2; i++) begin
            if (carry) begin
                if (v[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic digit_ok(input logic [3:0] d);
        return d <= 4'd9;
    endfunction

    state_t      state_q,    state_d;
    state_t      resume_q,   resume_d;
    err_t        err_q,      err_d;
    logic [11:0] pills_q,    pills_d;
    logic [7:0]  bottles_q,  bottles_d;
    logic [2:0]  err_cnt_q,  err_cnt_d;
    logic [11:0] hop_tmr_q,  hop_tmr_d;
    logic [11:0] sw_tmr_q,   sw_tmr_d;

    logic        targets_valid;
    logic [11:0] pills_inc;
    logic [7:0]  bottles_inc;
    logic        raise_err;
    err_t        raise_code;
    state_t      raise_resume;

    assign targets_valid = digit_ok(target_pills[11:8]) && digit_ok(target_pills[7:4])
                        && digit_ok(target_pills[3:0])  && digit_ok(target_bottles[7:4])
                        && digit_ok(target_bottles[3:0])
                        && (target_pills != 12'h000) && (target_bottles != 8'h00);

    assign pills_inc   = bcd_inc3(pills_q);
    assign bottles_inc = bcd_inc2(bottles_q);

    always_comb begin
        // NOTE: every value driven here gets its hold value first, so no branch can infer a latch.
        state_d      = state_q;
        resume_d     = resume_q;
        err_d        = err_q;
        pills_d      = pills_q;
        bottles_d    = bottles_q;
        err_cnt_d    = err_cnt_q;
        hop_tmr_d    = hop_tmr_q;
        sw_tmr_d     = sw_tmr_q;
        raise_err    = 1'b0;
        raise_code   = ERR_NONE;
        raise_resume = ST_RUNNING;

        case (state_q)
            ST_SETTING: begin
                if (start && targets_valid) begin
                    state_d   = ST_RUNNING;
                    pills_d   = 12'h000;
                    bottles_d = 8'h00;
                    err_d     = ERR_NONE;
                    err_cnt_d = 3'd0;
                    hop_tmr_d = HOPPER_RELOAD;
                end
            end

            ST_RUNNING: begin
                if (estop) begin
                    state_d = ST_FATAL;
                    err_d   = ERR_ESTOP;
                end else if (pills_q == target_pills) begin
                    // Completion wins over a pill arriving on the same edge, so the count never passes target.
                    bottles_d = bottles_inc;
                    err_cnt_d = 3'd0;
                    if (bottles_inc == target_bottles) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d  = ST_SWITCHING;
                        sw_tmr_d = SWITCH_RELOAD;
                    end
                end else if (pill_pulse) begin
                    pills_d   = pills_inc;
                    hop_tmr_d = HOPPER_RELOAD;
                end else if (hop_tmr_q == 12'd0) begin
                    raise_err    = 1'b1;
                    raise_code   = ERR_HOPPER;
                    raise_resume = ST_RUNNING;
                end else begin
                    hop_tmr_d = hop_tmr_q - 12'd1;
                end
            end

            ST_SWITCHING: begin
                if (estop) begin
                    state_d = ST_FATAL;
                    err_d   = ERR_ESTOP;
                end else if (sw_tmr_q == 12'd0) begin
                    if (conveyor_ok) begin
                        state_d   = ST_RUNNING;
                        pills_d   = 12'h000;
                        hop_tmr_d = HOPPER_RELOAD;
                    end else begin
                        raise_err    = 1'b1;
                        raise_code   = ERR_CONVEYOR;
                        raise_resume = ST_SWITCHING;
                    end
                end else begin
                    sw_tmr_d = sw_tmr_q - 12'd1;
                end
            end

            ST_ERROR: begin
                if (estop) begin
                    state_d = ST_FATAL;
                    err_d   = ERR_ESTOP;
                end else if (clr_err) begin
                    state_d = resume_q;
                    err_d   = ERR_NONE;
                    if (resume_q == ST_SWITCHING) begin
                        sw_tmr_d = SWITCH_RELOAD;
                    end else begin
                        hop_tmr_d = HOPPER_RELOAD;
                    end
                end
            end

            ST_DONE: begin
                if (start) begin
                    state_d = ST_SETTING;
                end
            end

            ST_FATAL: begin
            end

            default: begin
                state_d = ST_SETTING;
            end
        endcase

        // Every error entry is counted; the one that hits the limit lands in FATAL with its own cause code.
        if (raise_err) begin
            err_cnt_d = err_cnt_q + 3'd1;
            err_d     = raise_code;
            resume_d  = raise_resume;
            if (err_cnt_d >= ERROR_LIMIT) begin
                state_d = ST_FATAL;
            end else begin
                state_d = ST_ERROR;
            end
        end
    end

    // NOTE: registers use non-blocking assignment so all of them sample the pre-edge values together.
    always_ff @(posedge clk_1khz or negedge switch_clr) begin
        if (!switch_clr) begin
            state_q   <= ST_SETTING;
            resume_q  <= ST_RUNNING;
            err_q     <= ERR_NONE;
            pills_q   <= 12'h000;
            bottles_q <= 8'h00;
            err_cnt_q <= 3'd0;
            hop_tmr_q <= 12'd0;
            sw_tmr_q  <= 12'd0;
        end else begin
            state_q   <= state_d;
            resume_q  <= resume_d;
            err_q     <= err_d;
            pills_q   <= pills_d;
            bottles_q <= bottles_d;
            err_cnt_q <= err_cnt_d;
            hop_tmr_q <= hop_tmr_d;
            sw_tmr_q  <= sw_tmr_d;
        end
    end

    assign state       = state_q;
    assign now_pills   = pills_q;
    assign now_bottles = bottles_q;
    assign err_code    = err_q;

    always_comb begin
        case (state_q)
            ST_DONE:  alarm = 2'd1;
            ST_ERROR: alarm = 2'd2;
            ST_FATAL: alarm = 2'd3;
            default:  alarm = 2'd0;
        endcase
    end

endmodule

// File: tb/tb_fill_sequencer.sv
// Self-checking bench for fill_sequencer: a decimal/deadline model compared every
// cycle, plus directed literal checks taken from the operating scenarios.
module tb_fill_sequencer;

    localparam int HT = 3000;
    localparam int ST = 2000;
    localparam int ME = 3;

    localparam int S_SET = 0, S_RUN = 1, S_SW = 2, S_DONE = 3, S_ERR = 4, S_FAT = 5;

    logic        clk_1khz = 1'b0;
    logic        switch_clr;
    logic        start;
    logic        clr_err;
    logic        estop;
    logic        pill_pulse;
    logic        conveyor_ok;
    logic [11:0] target_pills;
    logic [7:0]  target_bottles;
    logic [2:0]  state;
    logic [11:0] now_pills;
    logic [7:0]  now_bottles;
    logic [1:0]  err_code;
    logic [1:0]  alarm;

    int checks   = 0;
    int failures = 0;

    fill_sequencer #(
        .HOPPER_TIMEOUT(HT),
        .SWITCH_TIME   (ST),
        .MAX_ERRORS    (ME)
    ) dut (
        .clk_1khz      (clk_1khz),
        .switch_clr    (switch_clr),
        .start         (start),
        .clr_err       (clr_err),
        .estop         (estop),
        .pill_pulse    (pill_pulse),
        .conveyor_ok   (conveyor_ok),
        .target_pills  (target_pills),
        .target_bottles(target_bottles),
        .state         (state),
        .now_pills     (now_pills),
        .now_bottles   (now_bottles),
        .err_code      (err_code),
        .alarm         (alarm)
    );

    always #5 clk_1khz = ~clk_1khz;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model: decimal counts, absolute deadlines ----------------
    int     m_state, m_pills, m_bottles, m_err, m_errcnt;
    bit     m_resume_sw;
    longint cyc, hop_dl, sw_dl;

    function automatic int bcd_val(input logic [11:0] v);
        return int'(v[11:8]) * 100 + int'(v[7:4]) * 10 + int'(v[3:0]);
    endfunction

    function automatic bit targets_ok(input logic [11:0] p, input logic [7:0] b);
        return (p[11:8] <= 4'd9) && (p[7:4] <= 4'd9) && (p[3:0] <= 4'd9)
            && (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9) && (p != 12'h000) && (b != 8'h00);
    endfunction

    function automatic logic [11:0] to_bcd3(input int v);
        logic [3:0] h, t, o;
        h = 4'(v / 100);
        t = 4'((v / 10) % 10);
        o = 4'(v % 10);
        return {h, t, o};
    endfunction

    function automatic int alarm_of(input int s);
        if (s == S_DONE) return 1;
        if (s == S_ERR)  return 2;
        if (s == S_FAT)  return 3;
        return 0;
    endfunction

    task automatic model_raise(input int code, input bit resume_sw);
        m_errcnt++;
        m_err       = code;
        m_resume_sw = resume_sw;
        m_state     = (m_errcnt >= ME) ? S_FAT : S_ERR;
    endtask

    task automatic model_step();
        cyc++;
        if (!switch_clr) begin
            m_state = S_SET; m_pills = 0; m_bottles = 0; m_err = 0; m_errcnt = 0;
            m_resume_sw = 1'b0;
        end else begin
            case (m_state)
                S_SET: if (start && targets_ok(target_pills, target_bottles)) begin
                    m_state = S_RUN; m_pills = 0; m_bottles = 0; m_err = 0; m_errcnt = 0;
                    hop_dl  = cyc + HT + 1;
                end
                S_RUN: begin
                    if (estop) begin
                        m_state = S_FAT; m_err = 3;
                    end else if (m_pills == bcd_val(target_pills)) begin
                        m_bottles = (m_bottles + 1) % 100;
                        m_errcnt  = 0;
                        if (m_bottles == bcd_val({4'h0, target_bottles})) m_state = S_DONE;
                        else begin m_state = S_SW; sw_dl = cyc + ST + 1; end
                    end else if (pill_pulse) begin
                        m_pills++;
                        hop_dl = cyc + HT + 1;
                    end else if (cyc == hop_dl) begin
                        model_raise(1, 1'b0);
                    end
                end
                S_SW: begin
                    if (estop) begin
                        m_state = S_FAT; m_err = 3;
                    end else if (cyc == sw_dl) begin
                        if (conveyor_ok) begin
                            m_state = S_RUN; m_pills = 0; hop_dl = cyc + HT + 1;
                        end else begin
                            model_raise(2, 1'b1);
                        end
                    end
                end
                S_ERR: begin
                    if (estop) begin
                        m_state = S_FAT; m_err = 3;
                    end else if (clr_err) begin
                        m_err = 0;
                        if (m_resume_sw) begin m_state = S_SW;  sw_dl  = cyc + ST + 1; end
                        else             begin m_state = S_RUN; hop_dl = cyc + HT + 1; end
                    end
                end
                S_DONE: if (start) m_state = S_SET;
                default: ;
            endcase
        end
    endtask

    // Model advances on each edge; DUT outputs are compared 1 time unit later.
    initial begin : compare_proc
        cyc = 0; hop_dl = -1; sw_dl = -1;
        forever begin
            @(posedge clk_1khz);
            model_step();
            #1;
            check("model.state",   32'(state),       32'(m_state));
            check("model.pills",   32'(now_pills),   32'(to_bcd3(m_pills)));
            check("model.bottles", 32'(now_bottles), 32'(to_bcd3(m_bottles)));
            check("model.err",     32'(err_code),    32'(m_err));
            check("model.alarm",   32'(alarm),       32'(alarm_of(m_state)));
        end
    end

    // ---------------- stimulus: inputs change only on the falling edge ----------------
    task automatic cyc_n(input int n);
        repeat (n) @(negedge clk_1khz);
    endtask

    task automatic pulse_start();
        start = 1'b1; cyc_n(1); start = 1'b0;
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1; cyc_n(1); clr_err = 1'b0;
    endtask

    task automatic pills(input int n);
        pill_pulse = 1'b1; cyc_n(n); pill_pulse = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk_1khz);
        switch_clr = 1'b0;
        cyc_n(2);
        check("reset.state", 32'(state), 0);
        check("reset.err",   32'(err_code), 0);
        switch_clr = 1'b1;
        cyc_n(1);
    endtask

    initial begin : stimulus
        switch_clr = 1'b0; start = 1'b0; clr_err = 1'b0; estop = 1'b0;
        pill_pulse = 1'b0; conveyor_ok = 1'b1;
        target_pills = 12'h003; target_bottles = 8'h02;

        // Two bottles of three pills with a switch in between.
        do_reset();
        check("s1.reset.pills",   32'(now_pills), 0);
        check("s1.reset.bottles", 32'(now_bottles), 0);
        check("s1.reset.alarm",   32'(alarm), 0);
        pulse_start();
        check("s1.run", 32'(state), S_RUN);
        for (int i = 1; i <= 3; i++) begin
            cyc_n(9);
            pills(1);
            check("s1.pills", 32'(now_pills), 32'(i));
        end
        check("s1.still_run", 32'(state), S_RUN);
        cyc_n(1);
        check("s1.switching", 32'(state), S_SW);
        check("s1.bottle1",   32'(now_bottles), 32'h01);
        cyc_n(ST);
        check("s1.sw_hold", 32'(state), S_SW);
        cyc_n(1);
        check("s1.back_run",  32'(state), S_RUN);
        check("s1.pills_clr", 32'(now_pills), 0);
        for (int i = 0; i < 3; i++) begin
            cyc_n(4);
            pills(1);
        end
        cyc_n(1);
        check("s1.done",    32'(state), S_DONE);
        check("s1.bottle2", 32'(now_bottles), 32'h02);
        check("s1.alarm",   32'(alarm), 1);
        pulse_clr();
        check("s1.clr_ignored", 32'(state), S_DONE);
        pulse_start();
        check("s1.setting", 32'(state), S_SET);
        check("s1.held",    32'(now_bottles), 32'h02);

        // Hopper starvation and recovery.
        do_reset();
        target_pills = 12'h005; target_bottles = 8'h01;
        pulse_start();
        cyc_n(HT);
        check("s2.pre_timeout", 32'(state), S_RUN);
        cyc_n(1);
        check("s2.error",     32'(state), S_ERR);
        check("s2.err_code",  32'(err_code), 1);
        check("s2.alarm",     32'(alarm), 2);
        pulse_clr();
        check("s2.resumed",   32'(state), S_RUN);
        check("s2.err_clr",   32'(err_code), 0);
        cyc_n(2);
        pills(2);
        cyc_n(HT);
        check("s2.pre_timeout2", 32'(state), S_RUN);
        cyc_n(1);
        check("s2.error2", 32'(state), S_ERR);
        pulse_start();
        check("s2.start_ignored", 32'(state), S_ERR);
        pulse_clr();
        check("s2.resumed2",   32'(state), S_RUN);
        check("s2.pills_kept", 32'(now_pills), 32'h002);
        pills(3);
        cyc_n(1);
        check("s2.done", 32'(state), S_DONE);

        // Conveyor stopped three times in a row escalates to FATAL.
        do_reset();
        target_pills = 12'h002; target_bottles = 8'h05;
        pulse_start();
        pills(2);
        conveyor_ok = 1'b0;
        cyc_n(1);
        check("s3.switching", 32'(state), S_SW);
        for (int k = 1; k <= 3; k++) begin
            cyc_n(ST + 1);
            if (k < 3) begin
                check("s3.error",    32'(state), S_ERR);
                check("s3.err_code", 32'(err_code), 2);
                pulse_clr();
                check("s3.resume_sw", 32'(state), S_SW);
            end
        end
        check("s3.fatal",     32'(state), S_FAT);
        check("s3.fatal_err", 32'(err_code), 2);
        check("s3.alarm",     32'(alarm), 3);
        conveyor_ok = 1'b1;

        // BCD carries, then emergency stop.
        do_reset();
        target_pills = 12'h999; target_bottles = 8'h01;
        pulse_start();
        pills(9);
        check("s4.p009", 32'(now_pills), 32'h009);
        pills(90);
        check("s4.p099", 32'(now_pills), 32'h099);
        pills(1);
        check("s4.p100", 32'(now_pills), 32'h100);
        estop = 1'b1; pill_pulse = 1'b1;
        cyc_n(1);
        estop = 1'b0; pill_pulse = 1'b0;
        check("s4.fatal",     32'(state), S_FAT);
        check("s4.err3",      32'(err_code), 3);
        check("s4.pill_held", 32'(now_pills), 32'h100);
        pulse_start();
        pulse_clr();
        cyc_n(5);
        check("s4.absorbing", 32'(state), S_FAT);
        do_reset();
        check("s4.cleared", 32'(state), S_SET);
        check("s4.pills0",  32'(now_pills), 0);

        // Invalid targets, then a pill on the completion edge.
        target_pills = 12'h0A0; target_bottles = 8'h01;
        pulse_start();
        check("s5.bad_nibble", 32'(state), S_SET);
        target_pills = 12'h000;
        pulse_start();
        check("s5.zero_pills", 32'(state), S_SET);
        target_pills = 12'h005; target_bottles = 8'h00;
        pulse_start();
        check("s5.zero_bottles", 32'(state), S_SET);
        target_pills = 12'h002; target_bottles = 8'h02;
        pulse_start();
        check("s5.run", 32'(state), S_RUN);
        pills(2);
        check("s5.at_target", 32'(now_pills), 32'h002);
        pills(1);
        check("s5.switching",   32'(state), S_SW);
        check("s5.no_overfill", 32'(now_pills), 32'h002);
        pills(5);
        check("s5.sw_ignores", 32'(now_pills), 32'h002);

        cyc_n(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
